// File: rtl/ram_pkg.sv
// ram_pkg: shared widths and controller state encoding for the RAM burst controller
package ram_pkg;
  localparam int ADDR_W_DEF = 10;
  localparam int DATA_W_DEF = 8;
  localparam int LEN_W_DEF = 4;
  typedef enum logic [2:0] {IDLE, TURN, WRITE, RD_ISSUE, RD_CAP} state_t;
endpackage

// File: rtl/ram_addr_gen.sv
// ram_addr_gen: burst address counter with wrap plus remaining-beat count and last flag
//   load/load_addr/load_len start a burst; inc advances one completed beat
//   addr = current beat address, next_addr = address after this edge, last = current beat is final
module ram_addr_gen import ram_pkg::*; #(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int LEN_W = LEN_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              inc,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [LEN_W-1:0]  load_len,
  output logic [ADDR_W-1:0] addr,
  output logic [ADDR_W-1:0] next_addr,
  output logic              last
);
  logic [LEN_W-1:0] left;
  assign next_addr = load ? load_addr : inc ? addr + 1'b1 : addr;
  assign last = left == '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      addr <= '0;
      left <= '0;
    end else begin
      addr <= next_addr;
      if (load) left <= load_len;
      else if (inc && !last) left <= left - 1'b1;
    end
  end
endmodule

// File: rtl/ram_burst_ctrl.sv
// ram_burst_ctrl: burst command front end for a single-port synchronous RAM
//   cmd_*: burst command (write/read, start address, length-1)
//   wr_*: write beat stream in; rd_*: read beat stream out with rd_last on the final beat
//   Address/Data/RW/En: registered RAM port; Data is driven only during write accesses
module ram_burst_ctrl import ram_pkg::*; #(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int LEN_W = LEN_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_last,
  output logic [ADDR_W-1:0] Address,
  inout  wire  [DATA_W-1:0] Data,
  output logic              RW,
  output logic              En
);
  state_t state, state_nx;
  logic prev_rd, accept, wr_fire, rd_fire, last;
  logic [ADDR_W-1:0] cur_addr, next_addr;
  logic [DATA_W-1:0] data_q;
  assign cmd_ready = state == IDLE && !rst;
  assign wr_ready = state == WRITE && !rst;
  assign accept = cmd_valid && cmd_ready;
  assign wr_fire = wr_valid && wr_ready;
  assign rd_fire = state == RD_CAP && rd_valid && rd_ready;
  assign Data = (RW && En) ? data_q : 'z;
  ram_addr_gen #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) u_addr (
    .clk(clk), .rst(rst), .load(accept), .inc(wr_fire || rd_fire),
    .load_addr(cmd_addr), .load_len(cmd_len),
    .addr(cur_addr), .next_addr(next_addr), .last(last)
  );
  // A write after a read inserts TURN so the RAM's read drive is off the bus first
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     state_nx = !accept ? IDLE : !cmd_write ? RD_ISSUE : prev_rd ? TURN : WRITE;
      TURN:     state_nx = WRITE;
      WRITE:    state_nx = (wr_fire && last) ? IDLE : WRITE;
      RD_ISSUE: state_nx = RD_CAP;
      RD_CAP:   state_nx = !rd_fire ? RD_CAP : last ? IDLE : RD_ISSUE;
      default:  state_nx = IDLE;
    endcase
  end
  // RAM port is registered from the next-state decision so accesses line up with the state
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      prev_rd <= 1'b0;
      Address <= '0;
      RW <= 1'b0;
      En <= 1'b0;
      data_q <= '0;
      rd_valid <= 1'b0;
      rd_last <= 1'b0;
      rd_data <= '0;
    end else begin
      state <= state_nx;
      if (accept) prev_rd <= !cmd_write;
      En <= wr_fire || state_nx == RD_ISSUE;
      RW <= wr_fire;
      if (wr_fire) begin
        Address <= cur_addr;
        data_q <= wr_data;
      end else if (state_nx == RD_ISSUE) begin
        Address <= next_addr;
      end
      if (state == RD_CAP && !rd_valid) begin
        rd_data <= Data;
        rd_valid <= 1'b1;
        rd_last <= last;
      end else if (rd_fire) begin
        rd_valid <= 1'b0;
        rd_last <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_ram_burst_ctrl.sv
// tb_ram_burst_ctrl: directed table, corner sequences and random bursts against a RAM model
module tb_ram_burst_ctrl;
  localparam int AW = 10;
  localparam int DW = 8;
  localparam int LW = 4;
  logic clk = 0;
  logic rst = 1;
  logic cmd_valid = 0;
  logic cmd_write = 0;
  logic [AW-1:0] cmd_addr = '0;
  logic [LW-1:0] cmd_len = '0;
  logic wr_valid = 0;
  logic [DW-1:0] wr_data = '0;
  logic rd_ready = 0;
  logic cmd_ready, wr_ready, rd_valid, rd_last, RW, En;
  logic [DW-1:0] rd_data;
  logic [AW-1:0] Address;
  wire [DW-1:0] Data;
  logic [DW-1:0] mem [1024];
  logic [DW-1:0] ref_mem [1024];
  logic [DW-1:0] ram_q;
  logic ram_drv;
  bit ram_init = 0;
  bit prev_rd = 0;
  int passed = 0;
  int total = 0;
  logic [AW+DW-1:0] wq [$];
  logic [AW-1:0] rq [$];
  typedef struct {
    bit w;
    int a;
    int l;
    logic [7:0] d [16];
    bit gaps;
    int stall;
  } vec_t;
  vec_t tbl [6];

  always #5 clk = ~clk;

  ram_burst_ctrl dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
    .Address(Address), .Data(Data), .RW(RW), .En(En)
  );

  // synchronous RAM: read data appears on the bus for the cycle after the read access
  assign Data = ram_drv ? ram_q : 'z;
  always @(posedge clk) begin
    if (!ram_init) begin
      for (int i = 0; i < 1024; i++) mem[i] <= '0;
      ram_drv <= 1'b0;
      ram_q <= '0;
      ram_init <= 1'b1;
    end else begin
      ram_drv <= En && !RW;
      if (En && RW) mem[Address] <= Data;
      if (En && !RW) ram_q <= mem[Address];
    end
  end

  always @(negedge clk) begin
    if (En) begin
      if (RW) wq.push_back({Address, Data});
      else rq.push_back(Address);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic set_vec(input int i, input bit w, input int a, input int l,
                         input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                         input logic [7:0] b3, input bit gaps, input int stall);
    tbl[i].w = w;
    tbl[i].a = a;
    tbl[i].l = l;
    for (int k = 0; k < 16; k++) tbl[i].d[k] = '0;
    tbl[i].d[0] = b0;
    tbl[i].d[1] = b1;
    tbl[i].d[2] = b2;
    tbl[i].d[3] = b3;
    tbl[i].gaps = gaps;
    tbl[i].stall = stall;
  endtask

  task automatic send_cmd(input bit w, input int a, input int l);
    int n = 0;
    @(negedge clk);
    cmd_valid = 1;
    cmd_write = w;
    cmd_addr = AW'(a);
    cmd_len = LW'(l);
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("cmd_accept", 32'(n < 50), 1);
    @(posedge clk);
    #1 cmd_valid = 0;
  endtask

  task automatic write_burst(input int a, input int l, input logic [7:0] d [16], input bit gaps);
    int n;
    bit turn = prev_rd;
    wq.delete();
    send_cmd(1, a, l);
    prev_rd = 0;
    @(negedge clk);
    chk("turn_wr_ready", 32'(wr_ready), 32'(!turn));
    if (turn) chk("turn_bus_idle", {cmd_ready, En, RW}, 0);
    for (int i = 0; i <= l; i++) begin
      if (gaps)
        for (int g = $urandom_range(0, 2); g > 0; g--) begin
          wr_valid = 0;
          @(negedge clk);
        end
      wr_valid = 1;
      wr_data = d[i];
      n = 0;
      while (!wr_ready && n < 20) begin
        @(negedge clk);
        n++;
      end
      @(negedge clk);
    end
    wr_valid = 0;
    repeat (2) @(negedge clk);
    for (int i = 0; i <= l; i++) ref_mem[(a + i) % 1024] = d[i];
    chk("wr_access_count", wq.size(), l + 1);
    for (int i = 0; i < wq.size() && i <= l; i++) begin
      chk("wr_addr", 32'(wq[i][AW+DW-1:DW]), (a + i) % 1024);
      chk("wr_data", 32'(wq[i][DW-1:0]), 32'(d[i]));
    end
  endtask

  task automatic read_burst(input int a, input int l, input int stall, input logic [7:0] exp [16]);
    int n;
    rq.delete();
    rd_ready = 1;
    send_cmd(0, a, l);
    prev_rd = 1;
    for (int i = 0; i <= l; i++) begin
      n = 1;
      @(negedge clk);
      while (!rd_valid && n < 20) begin
        @(negedge clk);
        n++;
      end
      chk("rd_latency", n, 3);
      if (i == stall) begin
        rd_ready = 0;
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          chk("stall_hold", {rd_valid, En, rd_data}, {1'b1, 1'b0, exp[i]});
        end
        chk("stall_no_access", rq.size(), i + 1);
        rd_ready = 1;
      end
      chk("rd_data", 32'(rd_data), 32'(exp[i]));
      chk("rd_last", 32'(rd_last), 32'(i == l));
    end
    @(negedge clk);
    chk("rd_burst_done", {rd_valid, cmd_ready}, 2'b01);
    chk("rd_access_count", rq.size(), l + 1);
    for (int i = 0; i < rq.size() && i <= l; i++) chk("rd_addr", 32'(rq[i]), (a + i) % 1024);
  endtask

  initial begin
    logic [7:0] d [16];
    int n;
    for (int i = 0; i < 1024; i++) ref_mem[i] = '0;
    set_vec(0, 1, 3, 0, 8'hF0, 8'h00, 8'h00, 8'h00, 0, -1);
    set_vec(1, 0, 3, 0, 8'hF0, 8'h00, 8'h00, 8'h00, 0, -1);
    set_vec(2, 1, 1022, 3, 8'hAA, 8'h55, 8'h0F, 8'hF0, 0, -1);
    set_vec(3, 0, 1022, 3, 8'hAA, 8'h55, 8'h0F, 8'hF0, 0, -1);
    set_vec(4, 1, 500, 3, 8'h12, 8'h34, 8'h56, 8'h78, 1, -1);
    set_vec(5, 0, 500, 3, 8'h12, 8'h34, 8'h56, 8'h78, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", {cmd_ready, wr_ready, rd_valid, rd_last, rd_data, Address, RW, En}, 0);
    rst = 0;
    for (int v = 0; v < 6; v++)
      if (tbl[v].w) write_burst(tbl[v].a, tbl[v].l, tbl[v].d, tbl[v].gaps);
      else read_burst(tbl[v].a, tbl[v].l, tbl[v].stall, tbl[v].d);
    rd_ready = 1;
    send_cmd(0, 1022, 3);
    n = 0;
    while (!rd_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("rst_pre_valid", 32'(rd_valid), 1);
    rst = 1;
    @(negedge clk);
    chk("mid_burst_reset", {cmd_ready, wr_ready, rd_valid, rd_last, rd_data, Address, RW, En}, 0);
    rst = 0;
    prev_rd = 0;
    rq.delete();
    wq.delete();
    repeat (4) @(negedge clk);
    chk("no_access_after_rst", rq.size() + wq.size(), 0);
    for (int k = 0; k < 16; k++) d[k] = 8'(k * 17 + 3);
    write_burst(20, 2, d, 0);
    for (int k = 0; k < 16; k++) d[k] = ref_mem[(1022 + k) % 1024];
    read_burst(1022, 3, -1, d);
    for (int r = 0; r < 30; r++) begin
      int a = $urandom_range(0, 1023);
      int l = $urandom_range(0, 15);
      if ($urandom_range(0, 1) == 1) begin
        for (int k = 0; k < 16; k++) d[k] = 8'($urandom);
        write_burst(a, l, d, 1'($urandom_range(0, 1)));
      end else begin
        for (int k = 0; k < 16; k++) d[k] = ref_mem[(a + k) % 1024];
        read_burst(a, l, $urandom_range(0, 20), d);
      end
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/ram_burst_ctrl.md
RAM_BURST_CTRL -- requirements
Module: ram_burst_ctrl

Interface
REQ-001 Parameters SHALL be: ADDR_W default 10, RAM address width; DATA_W default 8, RAM data width; LEN_W default 4, burst length field width.
REQ-002 clk  input  1  single clock; all state SHALL change on its rising edge only.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 cmd_valid  input  1  command offered.
REQ-005 cmd_ready  output  1  command accepted when cmd_valid && cmd_ready at a rising edge.
REQ-006 cmd_write  input  1  1 = write burst, 0 = read burst.
REQ-007 cmd_addr  input  ADDR_W  burst start address.
REQ-008 cmd_len  input  LEN_W  burst length minus one (0 = 1 word, 15 = 16 words).
REQ-009 wr_valid / wr_ready / wr_data  input / output / input DATA_W  write-data stream; beat transfers when wr_valid && wr_ready.
REQ-010 rd_valid / rd_ready / rd_data / rd_last  output / input / output DATA_W / output  read-data stream; beat transfers when rd_valid && rd_ready; rd_last marks the final beat.
REQ-011 Address  output  ADDR_W  RAM address.
REQ-012 Data  inout  DATA_W  RAM bidirectional data bus.
REQ-013 RW  output  1  RAM direction, 1 = write, 0 = read.
REQ-014 En  output  1  RAM enable; RAM acts only when En = 1 at a rising edge.

Function
REQ-015 States SHALL be IDLE, TURN, WRITE, RD_ISSUE, RD_CAP.
REQ-016 IDLE: cmd_ready = 1, En = 0; on acceptance latch addr, len, direction; go WRITE (or TURN if the previous burst was a read), else RD_ISSUE.
REQ-017 TURN: exactly one cycle with En = 0, RW = 0, Data released; then WRITE.
REQ-018 cmd_ready SHALL be 0 in every state except IDLE.
REQ-019 WRITE: wr_ready = 1; each accepted beat SHALL produce, in the next cycle, exactly one cycle of En = 1, RW = 1, Address = current address, Data driven with that beat.
REQ-020 WRITE with wr_valid = 0: En = 0 next cycle, no RAM access, address unchanged.
REQ-021 RD_ISSUE: one cycle En = 1, RW = 0, Address = current address; Data released; next state RD_CAP.
REQ-022 RD_CAP: at the first edge, Data SHALL be captured into rd_data; rd_valid = 1 held with rd_data stable until rd_ready; En = 0 throughout.
REQ-023 After each read handshake: RD_ISSUE for the next word, or IDLE after the last word; rd_last = 1 only with the final beat.
REQ-024 Address SHALL increment by 1 per completed beat, modulo 2^ADDR_W (1023 wraps to 0).
REQ-025 Data SHALL be driven only when RW = 1 and En = 1; high-Z otherwise.
REQ-026 Burst SHALL complete after exactly cmd_len+1 beats; no command is accepted mid-burst.
REQ-027 Read latency: cmd acceptance to first rd_valid = 3 cycles; minimum 3 cycles per read beat, 1 per write beat.

Reset
REQ-028 While rst = 1 at an edge: state IDLE, cmd_ready 0 for that cycle, wr_ready 0, rd_valid 0, rd_last 0, rd_data 0, Address 0, RW 0, En 0, Data high-Z, previous-direction flag = write.
REQ-029 Reset mid-burst SHALL abandon the burst with no further RAM access; remaining beats are discarded.

Structure
REQ-030 ADDR_W, DATA_W, LEN_W defaults and the state encoding SHALL live in shared package ram_pkg.
REQ-031 Address counter with wrap and beat/last counting SHALL be sub-module ram_addr_gen (load, increment, last flag).
REQ-032 RTL SHALL be 120-400 lines, RAM-side outputs registered.

Verification
REQ-033 Write burst addr 3, len 0, data F0 -> one cycle En=1 RW=1 Address=3 Data=F0; read back -> rd_data F0, rd_last 1.
REQ-034 Write len 3 at addr 1022 data AA,55,0F,F0 -> writes to 1022,1023,0,1; read burst same -> same four bytes in order, rd_last on fourth.
REQ-035 Read burst with rd_ready held 0 for 5 cycles -> rd_valid and rd_data stable, En stays 0, no extra RAM access.
REQ-036 Read then write command back-to-back -> exactly one TURN cycle with En=0 and Data high-Z before first write.
REQ-037 Write burst with wr_valid gaps -> En=1 only for accepted beats; addresses contiguous.
REQ-038 rst asserted mid read burst -> next cycle all outputs at reset values; new command after reset runs normally.
